branch_resolve: RTL and testbench

//  Execute-stage branch/jump resolution and fetch-PC owner for the RV32I core. Consumes

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_cond.sv | 29 ++
 rtl/branch_resolve.sv | 119 +++++++++++
 tb/tb_branch_resolve.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for execute-stage branch resolution.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  // Wide enough for a flush window of up to 7 cycles.
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

endpackage

// File: rtl/branch_cond.sv
// Maps funct3 plus comparator flags to a branch condition and an illegal-encoding flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       cond,
  output logic       illegal
);

  // Decode the condition; 010/011 are reserved encodings and never taken.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:     cond = equal;
      BNE:     cond = ~equal;
      BLT:     cond = less;
      BGE:     cond = ~less;
      BLTU:    cond = less;
      BGEU:    cond = ~less;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves EX-stage branches/jumps, owns the fetch PC and flushes wrong-path IF/ID slots.
// Latency: decision combinational; pc_o/flush_o reflect it one edge later.
// Backpressure: stall_i holds PC and flush counter and suppresses resolution.
// Optional build macro BRANCH_PERF_CNT_EN adds saturating branch/taken counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic        is_branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  funct3_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  output logic        br_unsigned_o,
  output logic [31:0] pc_o,
  output logic        redirect_o,
  output logic        flush_o,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [31:0] br_count_o,
  output logic [31:0] taken_count_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   res;
  logic                   cond;
  logic                   cond_illegal;
  logic                   taken;
  logic [XLEN-1:0]        target;

  branch_cond u_cond (
    .funct3  (funct3_i),
    .less    (br_less_i),
    .equal   (br_equal_i),
    .cond    (cond),
    .illegal (cond_illegal)
  );

  assign br_unsigned_o = funct3_i[1];

  // Wrong-path instructions still in EX during a flush window are ignored.
  assign res = valid_i & ~stall_i & (flush_cnt == '0);

  // Jump flags win over the branch condition; JALR clears bit 0 of its target.
  always_comb begin
    target = pc_ex_i + imm_i;
    if (is_jalr_i) begin
      target = (rs1_data_i + imm_i) & ~32'h1;
    end
  end

  assign taken      = res & (is_jal_i | is_jalr_i | (is_branch_i & cond));
  assign illegal_o  = res & is_branch_i & cond_illegal;
  // A half-word aligned target traps upstream, so fetch simply falls through.
  assign misalign_o = taken & target[1];
  assign redirect_o = taken & ~target[1];
  assign flush_o    = (flush_cnt != '0);

  // Fetch PC: stall holds, otherwise redirect target or sequential increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o <= RESET_VECTOR;
    end else if (!stall_i) begin
      pc_o <= redirect_o ? target : pc_o + PC_INC;
    end
  end

  // Flush window counter; a redirect cannot arrive while it is nonzero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt <= '0;
    end else if (!stall_i) begin
      if (redirect_o) begin
        flush_cnt <= FLUSH_LOAD;
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] tk_cnt_q;

  // Saturating counters of resolved legal branches and taken redirects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      if (res && is_branch_i && !cond_illegal && br_cnt_q != 32'hFFFF_FFFF) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (redirect_o && tk_cnt_q != 32'hFFFF_FFFF) begin
        tk_cnt_q <= tk_cnt_q + 32'd1;
      end
    end
  end

  assign br_count_o    = br_cnt_q;
  assign taken_count_o = tk_cnt_q;
`else
  assign br_count_o    = 32'h0;
  assign taken_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed table-driven bench for branch_resolve plus multi-cycle corner sequences.
// Latency: checks comb outputs mid-cycle and registered outputs #1 after posedge.
// Backpressure: exercises stall_i hold of PC and flush window.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, stall, valid, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        less, equal;
  logic [31:0] pc_ex, imm, rs1;
  logic        br_unsigned, redirect, flush, illegal, misalign;
  logic [31:0] pc, br_count, taken_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_tk = 0;

  always #5 clk = ~clk;

  branch_resolve #(.RESET_VECTOR(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .valid_i(valid),
    .is_branch_i(is_branch), .is_jal_i(is_jal), .is_jalr_i(is_jalr),
    .funct3_i(funct3), .br_less_i(less), .br_equal_i(equal),
    .pc_ex_i(pc_ex), .imm_i(imm), .rs1_data_i(rs1),
    .br_unsigned_o(br_unsigned), .pc_o(pc), .redirect_o(redirect),
    .flush_o(flush), .illegal_o(illegal), .misalign_o(misalign),
    .br_count_o(br_count), .taken_count_o(taken_count)
  );

  typedef struct {
    logic        v, br, jal, jalr;
    logic [2:0]  f3;
    logic        lt, eq;
    logic [31:0] pcx, im, r1;
    logic        e_rd, e_mis, e_ill;
    logic [31:0] tgt;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic idle();
    valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; less = 0; equal = 0; pc_ex = 0; imm = 0; rs1 = 0;
  endtask

  task automatic drive_br(input logic [2:0] f, input logic lt, input logic eq,
                          input logic [31:0] p, input logic [31:0] i);
    idle();
    valid = 1; is_branch = 1; funct3 = f; less = lt; equal = eq; pc_ex = p; imm = i;
  endtask

  task automatic edge_chk(input string name, input logic e_flush);
    @(posedge clk); #1;
    chk({name, "_pc"}, pc, exp_pc);
    chk({name, "_flush"}, {31'b0, flush}, {31'b0, e_flush});
  endtask

  task automatic chk_counts(input string name);
`ifdef BRANCH_PERF_CNT_EN
    chk({name, "_brcnt"}, br_count, exp_br);
    chk({name, "_tkcnt"}, taken_count, exp_tk);
`else
    chk({name, "_brcnt"}, br_count, 32'h0);
    chk({name, "_tkcnt"}, taken_count, 32'h0);
`endif
  endtask

  initial begin
    //            v  br jal jalr f3      lt eq pc_ex         imm           rs1           rd mis ill target
    vt[0]  = '{1, 1, 0, 0, 3'b000, 0, 1, 32'h100,      32'h20,       32'h0,   1, 0, 0, 32'h120};
    vt[1]  = '{1, 1, 0, 0, 3'b000, 0, 0, 32'h100,      32'h20,       32'h0,   0, 0, 0, 32'h0};
    vt[2]  = '{1, 1, 0, 0, 3'b001, 0, 0, 32'h200,      32'hFFFF_FFF0, 32'h0,  1, 0, 0, 32'h1F0};
    vt[3]  = '{1, 1, 0, 0, 3'b100, 1, 0, 32'h300,      32'h8,        32'h0,   1, 0, 0, 32'h308};
    vt[4]  = '{1, 1, 0, 0, 3'b101, 1, 0, 32'h300,      32'h8,        32'h0,   0, 0, 0, 32'h0};
    vt[5]  = '{1, 1, 0, 0, 3'b110, 0, 0, 32'h300,      32'h8,        32'h0,   0, 0, 0, 32'h0};
    vt[6]  = '{1, 1, 0, 0, 3'b111, 0, 0, 32'h400,      32'h40,       32'h0,   1, 0, 0, 32'h440};
    vt[7]  = '{1, 1, 0, 0, 3'b010, 1, 1, 32'h400,      32'h40,       32'h0,   0, 0, 1, 32'h0};
    vt[8]  = '{1, 1, 0, 0, 3'b011, 1, 1, 32'h400,      32'h40,       32'h0,   0, 0, 1, 32'h0};
    vt[9]  = '{1, 0, 1, 0, 3'b000, 0, 0, 32'h500,      32'h100,      32'h0,   1, 0, 0, 32'h600};
    vt[10] = '{1, 0, 0, 1, 3'b000, 0, 0, 32'h500,      32'h4,        32'h203, 0, 1, 0, 32'h0};
    vt[11] = '{1, 0, 0, 1, 3'b000, 0, 0, 32'h500,      32'h4,        32'h201, 1, 0, 0, 32'h204};
    vt[12] = '{1, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'h20,      32'h0,   1, 0, 0, 32'h10};
    vt[13] = '{0, 1, 0, 0, 3'b000, 0, 1, 32'h100,      32'h20,       32'h0,   0, 0, 0, 32'h0};
    vt[14] = '{1, 1, 0, 0, 3'b000, 0, 1, 32'h100,      32'h2,        32'h0,   0, 1, 0, 32'h0};

    // Reset held two cycles, then sequential fetch.
    rst = 1; stall = 0; idle();
    repeat (2) @(posedge clk);
    #1;
    exp_pc = 32'h0;
    chk("rst_pc", pc, exp_pc);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk_counts("rst");
    @(negedge clk); rst = 0;
    for (int k = 0; k < 3; k++) begin
      exp_pc = exp_pc + 32'd4;
      edge_chk("seq", 1'b0);
    end

    // Table: each vector resolves once, then any flush window drains.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      idle();
      valid = vt[i].v; is_branch = vt[i].br; is_jal = vt[i].jal; is_jalr = vt[i].jalr;
      funct3 = vt[i].f3; less = vt[i].lt; equal = vt[i].eq;
      pc_ex = vt[i].pcx; imm = vt[i].im; rs1 = vt[i].r1;
      #1;
      chk($sformatf("v%0d_redirect", i), {31'b0, redirect}, {31'b0, vt[i].e_rd});
      chk($sformatf("v%0d_misalign", i), {31'b0, misalign}, {31'b0, vt[i].e_mis});
      chk($sformatf("v%0d_illegal", i),  {31'b0, illegal},  {31'b0, vt[i].e_ill});
      chk($sformatf("v%0d_unsigned", i), {31'b0, br_unsigned}, {31'b0, vt[i].f3[1]});
      exp_pc = vt[i].e_rd ? vt[i].tgt : exp_pc + 32'd4;
      if (vt[i].v && vt[i].br && !vt[i].e_ill) exp_br++;
      if (vt[i].e_rd) exp_tk++;
      edge_chk($sformatf("v%0d", i), vt[i].e_rd);
      chk_counts($sformatf("v%0d", i));
      if (vt[i].e_rd) begin
        @(negedge clk); idle();
        exp_pc = exp_pc + 32'd4;
        edge_chk($sformatf("v%0d_drain1", i), 1'b1);
        exp_pc = exp_pc + 32'd4;
        edge_chk($sformatf("v%0d_drain2", i), 1'b0);
      end
    end

    // Branches arriving inside the flush window are ignored.
    @(negedge clk); drive_br(3'b000, 0, 1, 32'h800, 32'h40);
    #1 chk("fw_redirect0", {31'b0, redirect}, 32'h1);
    exp_pc = 32'h840; exp_br++; exp_tk++;
    edge_chk("fw0", 1'b1);
    @(negedge clk); drive_br(3'b000, 0, 1, 32'h900, 32'h10);
    #1 chk("fw_redirect1", {31'b0, redirect}, 32'h0);
    exp_pc = exp_pc + 32'd4;
    edge_chk("fw1", 1'b1);
    @(negedge clk); drive_br(3'b010, 0, 0, 32'h900, 32'h10);
    #1 chk("fw_illegal", {31'b0, illegal}, 32'h0);
    exp_pc = exp_pc + 32'd4;
    edge_chk("fw2", 1'b0);
    chk_counts("fw");

    // Stall suppresses a taken BNE and holds PC; release redirects next edge.
    @(negedge clk); drive_br(3'b001, 0, 0, 32'h700, 32'h10); stall = 1;
    #1 chk("st_redirect_held", {31'b0, redirect}, 32'h0);
    edge_chk("st_hold", 1'b0);
    @(negedge clk); stall = 0;
    #1 chk("st_redirect_rel", {31'b0, redirect}, 32'h1);
    exp_pc = 32'h710; exp_br++; exp_tk++;
    edge_chk("st_rel", 1'b1);
    // Stall inside the flush window freezes the counter.
    @(negedge clk); idle(); stall = 1;
    edge_chk("st_fhold", 1'b1);
    @(negedge clk); stall = 0;
    exp_pc = exp_pc + 32'd4;
    edge_chk("st_f1", 1'b1);
    exp_pc = exp_pc + 32'd4;
    edge_chk("st_f2", 1'b0);
    chk_counts("st");

    // Reset in the middle of a flush window clears everything on the same edge.
    @(negedge clk); idle(); valid = 1; is_jal = 1; pc_ex = 32'h0; imm = 32'h40;
    exp_pc = 32'h40; exp_tk++;
    edge_chk("rf_jal", 1'b1);
    @(negedge clk); idle(); rst = 1;
    exp_pc = 32'h0; exp_br = 0; exp_tk = 0;
    edge_chk("rf_rst", 1'b0);
    chk_counts("rf");
    @(negedge clk); rst = 0;
    exp_pc = 32'h4;
    edge_chk("rf_after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
